// File: rtl/placar_bcd.sv
// placar_bcd: multi-digit BCD up/down score counter.
//
// Holds a packed BCD count. Each nibble stays in 0..9 and drives one 7-segment digit decoder.
// Requests are applied with this priority:
//   1. clr
//   2. load (every nibble clamped to 9)
//   3. inc and dec together (hold)
//   4. inc
//   5. dec
// A wrap past the ends of the range raises a single-cycle overflow or underflow pulse.
// All outputs are registered and update on the edge that samples the request.
//
// Optional feature (macro PLACAR_INC_EDGE_EN):
//   Defined   - inc/dec are level inputs. Only their rising edges count.
//   Undefined - every cycle that inc/dec is high counts once.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   inc         in   increment request
//   dec         in   decrement request
//   clr         in   synchronous clear to zero
//   load        in   synchronous preset from valor_load
//   valor_load  in   preset value, BCD, digit i at [4i+3:4i]
//   digitos     out  current count, BCD, same packing
//   overflow    out  one-cycle pulse on wrap from all-9s to all-0s
//   underflow   out  one-cycle pulse on wrap from all-0s to all-9s
//   zero        out  high while digitos is all zeros
module placar_bcd #(
   parameter int unsigned NDIG = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic              dec,
   input  logic              clr,
   input  logic              load,
   input  logic [4*NDIG-1:0] valor_load,
   output logic [4*NDIG-1:0] digitos,
   output logic              overflow,
   output logic              underflow,
   output logic              zero
);

   logic [4*NDIG-1:0] count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              zero_q, zero_d;

   logic              inc_req, dec_req;
   logic [4*NDIG-1:0] inc_val, dec_val, load_val;
   logic              inc_carry, dec_borrow;

`ifdef PLACAR_INC_EDGE_EN
   logic inc_prev_q, dec_prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inc_prev_q <= 1'b0;
         dec_prev_q <= 1'b0;
      end else begin
         inc_prev_q <= inc;
         dec_prev_q <= dec;
      end
   end

   assign inc_req = inc & ~inc_prev_q;
   assign dec_req = dec & ~dec_prev_q;
`else
   assign inc_req = inc;
   assign dec_req = dec;
`endif

   // Carry chain: a digit moves only while every lower digit is 9.
   // A carry that survives the top digit means the counter was all 9s and has wrapped.
   always_comb begin
      inc_val   = count_q;
      inc_carry = 1'b1;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (inc_carry) begin
            if (count_q[4*i +: 4] == 4'd9) begin
               inc_val[4*i +: 4] = 4'd0;
            end else begin
               inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               inc_carry         = 1'b0;
            end
         end
      end
   end

   // Borrow chain: mirror of the carry chain, rippling across digits that are 0.
   always_comb begin
      dec_val    = count_q;
      dec_borrow = 1'b1;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (dec_borrow) begin
            if (count_q[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
               dec_borrow        = 1'b0;
            end
         end
      end
   end

   // Clamp non-BCD preset nibbles so the register never holds an invalid digit.
   always_comb begin
      load_val = '0;
      for (int i = 0; i < int'(NDIG); i++) begin
         load_val[4*i +: 4] = (valor_load[4*i +: 4] > 4'd9) ? 4'd9 : valor_load[4*i +: 4];
      end
   end

   always_comb begin
      count_d     = count_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (inc_req && dec_req) begin
         count_d = count_q;  // opposing requests cancel
      end else if (inc_req) begin
         count_d    = inc_val;
         overflow_d = inc_carry;
      end else if (dec_req) begin
         count_d     = dec_val;
         underflow_d = dec_borrow;
      end
      // Derived from the next value so zero never lags digitos.
      zero_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         zero_q      <= zero_d;
      end
   end

   assign digitos   = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_placar_bcd.sv
// Self-checking bench for placar_bcd (NDIG = 4).
// The reference model tracks the count as a plain integer and converts it to BCD for comparison.
module tb_placar_bcd;

   localparam int NDIG = 4;
   localparam int MAXV = 9999;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              inc;
   logic              dec;
   logic              clr;
   logic              load;
   logic [4*NDIG-1:0] valor_load;
   logic [4*NDIG-1:0] digitos;
   logic              overflow;
   logic              underflow;
   logic              zero;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int exp_val = 0;
   bit exp_ovf = 1'b0;
   bit exp_unf = 1'b0;
   bit m_prev_inc = 1'b0;
   bit m_prev_dec = 1'b0;

   placar_bcd #(.NDIG(NDIG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc),
      .dec       (dec),
      .clr       (clr),
      .load      (load),
      .valor_load(valor_load),
      .digitos   (digitos),
      .overflow  (overflow),
      .underflow (underflow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   function automatic logic [4*NDIG-1:0] to_bcd(input int v);
      logic [4*NDIG-1:0] b;
      int pw;
      b  = '0;
      pw = 1;
      for (int i = 0; i < NDIG; i++) begin
         b[4*i +: 4] = 4'((v / pw) % 10);
         pw = pw * 10;
      end
      return b;
   endfunction

   function automatic int clamp_val(input logic [4*NDIG-1:0] raw);
      int v;
      int pw;
      int n;
      v  = 0;
      pw = 1;
      for (int i = 0; i < NDIG; i++) begin
         n = int'(raw[4*i +: 4]);
         if (n > 9) n = 9;
         v  = v + n * pw;
         pw = pw * 10;
      end
      return v;
   endfunction

   task automatic model_step();
      bit ri;
      bit rd;
      if (!rst_n) begin
         exp_val    = 0;
         exp_ovf    = 1'b0;
         exp_unf    = 1'b0;
         m_prev_inc = 1'b0;
         m_prev_dec = 1'b0;
      end else begin
`ifdef PLACAR_INC_EDGE_EN
         ri = inc && !m_prev_inc;
         rd = dec && !m_prev_dec;
`else
         ri = inc;
         rd = dec;
`endif
         m_prev_inc = inc;
         m_prev_dec = dec;
         exp_ovf    = 1'b0;
         exp_unf    = 1'b0;
         if (clr) begin
            exp_val = 0;
         end else if (load) begin
            exp_val = clamp_val(valor_load);
         end else if (ri && rd) begin
            exp_val = exp_val;
         end else if (ri) begin
            if (exp_val == MAXV) begin
               exp_val = 0;
               exp_ovf = 1'b1;
            end else begin
               exp_val = exp_val + 1;
            end
         end else if (rd) begin
            if (exp_val == 0) begin
               exp_val = MAXV;
               exp_unf = 1'b1;
            end else begin
               exp_val = exp_val - 1;
            end
         end
      end
   endtask

   // One clock edge. The model samples the same inputs the DUT sees; outputs are read 1ns later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      inc        = 1'b0;
      dec        = 1'b0;
      clr        = 1'b0;
      load       = 1'b0;
      valor_load = '0;
   endtask

   task automatic do_load(input logic [4*NDIG-1:0] v);
      load       = 1'b1;
      valor_load = v;
      tick();
      load       = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (digitos !== 16'h0000 || zero !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: digitos=%h zero=%b ovf=%b unf=%b, want 0000 1 0 0",
                  digitos, zero, overflow, underflow);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (zero !== 1'b1) begin
         errors++;
         $display("FAIL zero_before_inc: zero=%b, want 1", zero);
      end
      for (int k = 0; k < 3; k++) begin
         inc = 1'b1;
         tick();
         inc = 1'b0;
         tick();
      end
      checks++;
      if (digitos !== 16'h0003 || zero !== 1'b0) begin
         errors++;
         $display("FAIL count_3: digitos=%h zero=%b, want 0003 0", digitos, zero);
      end
   endtask

   task automatic test_carry();
      do_load(16'h0999);
      inc = 1'b1;
      tick();
      inc = 1'b0;
      checks++;
      if (digitos !== 16'h1000 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL carry_0999: digitos=%h ovf=%b unf=%b, want 1000 0 0",
                  digitos, overflow, underflow);
      end
      do_load(16'h1000);
      dec = 1'b1;
      tick();
      dec = 1'b0;
      checks++;
      if (digitos !== 16'h0999 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL borrow_1000: digitos=%h ovf=%b unf=%b, want 0999 0 0",
                  digitos, overflow, underflow);
      end
   endtask

   task automatic test_wrap();
      do_load(16'h9999);
      inc = 1'b1;
      tick();
      inc = 1'b0;
      checks++;
      if (digitos !== 16'h0000 || overflow !== 1'b1 || underflow !== 1'b0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL wrap_up: digitos=%h ovf=%b unf=%b zero=%b, want 0000 1 0 1",
                  digitos, overflow, underflow, zero);
      end
      tick();
      checks++;
      if (overflow !== 1'b0 || digitos !== 16'h0000) begin
         errors++;
         $display("FAIL ovf_one_cycle: ovf=%b digitos=%h, want 0 0000", overflow, digitos);
      end
      dec = 1'b1;
      tick();
      dec = 1'b0;
      checks++;
      if (digitos !== 16'h9999 || underflow !== 1'b1 || overflow !== 1'b0 || zero !== 1'b0) begin
         errors++;
         $display("FAIL wrap_down: digitos=%h ovf=%b unf=%b zero=%b, want 9999 0 1 0",
                  digitos, overflow, underflow, zero);
      end
      tick();
      checks++;
      if (underflow !== 1'b0 || digitos !== 16'h9999) begin
         errors++;
         $display("FAIL unf_one_cycle: unf=%b digitos=%h, want 0 9999", underflow, digitos);
      end
   endtask

   task automatic test_priority();
      do_load(16'h0042);
      inc = 1'b1;
      dec = 1'b1;
      tick();
      inc = 1'b0;
      dec = 1'b0;
      checks++;
      if (digitos !== 16'h0042) begin
         errors++;
         $display("FAIL inc_dec_hold: digitos=%h, want 0042", digitos);
      end
      clr        = 1'b1;
      load       = 1'b1;
      inc        = 1'b1;
      valor_load = 16'h1234;
      tick();
      idle_inputs();
      checks++;
      if (digitos !== 16'h0000 || zero !== 1'b1) begin
         errors++;
         $display("FAIL clr_priority: digitos=%h zero=%b, want 0000 1", digitos, zero);
      end
      do_load(16'hA5F3);
      checks++;
      if (digitos !== 16'h9593 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL load_clamp: digitos=%h ovf=%b unf=%b, want 9593 0 0",
                  digitos, overflow, underflow);
      end
   endtask

   task automatic test_reset_mid();
      do_load(16'h0500);
      inc = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (digitos !== 16'h0000 || overflow !== 1'b0 || underflow !== 1'b0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: digitos=%h ovf=%b unf=%b zero=%b, want 0000 0 0 1",
                  digitos, overflow, underflow, zero);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (digitos !== 16'h0001) begin
         errors++;
         $display("FAIL resume_after_reset: digitos=%h, want 0001", digitos);
      end
      tick();
      checks++;
      if (digitos !== to_bcd(exp_val)) begin
         errors++;
         $display("FAIL resume_held: digitos=%h, want %h", digitos, to_bcd(exp_val));
      end
      inc = 1'b0;
      tick();
   endtask

`ifdef PLACAR_INC_EDGE_EN
   task automatic test_edge();
      int start;
      start = exp_val;
      inc   = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      inc = 1'b0;
      checks++;
      if (digitos !== to_bcd(start + 1)) begin
         errors++;
         $display("FAIL edge_held: digitos=%h, want %h", digitos, to_bcd(start + 1));
      end
      tick();
      inc = 1'b1;
      tick();
      tick();
      inc = 1'b0;
      checks++;
      if (digitos !== to_bcd(start + 2)) begin
         errors++;
         $display("FAIL edge_reassert: digitos=%h, want %h", digitos, to_bcd(start + 2));
      end
   endtask
`else
   task automatic test_level();
      int start;
      start = exp_val;
      inc   = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      inc = 1'b0;
      checks++;
      if (digitos !== to_bcd(start + 10)) begin
         errors++;
         $display("FAIL level_held: digitos=%h, want %h", digitos, to_bcd(start + 10));
      end
   endtask
`endif

   task automatic test_random();
      int r;
      for (int k = 0; k < 600; k++) begin
         r          = int'($urandom_range(0, 99));
         clr        = (r < 3);
         load       = (r >= 3 && r < 10);
         inc        = 1'($urandom_range(0, 1));
         dec        = 1'($urandom_range(0, 2) == 0);
         valor_load = 16'($urandom);
         rst_n      = ($urandom_range(0, 79) != 0);
         tick();
         checks++;
         if (digitos !== to_bcd(exp_val) || overflow !== exp_ovf || underflow !== exp_unf ||
             zero !== (exp_val == 0)) begin
            errors++;
            $display("FAIL random[%0d]: digitos=%h ovf=%b unf=%b zero=%b, want %h %b %b %b",
                     k, digitos, overflow, underflow, zero, to_bcd(exp_val), exp_ovf, exp_unf,
                     (exp_val == 0));
         end
      end
      rst_n = 1'b1;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      #2;
      test_reset();
      test_carry();
      test_wrap();
      test_priority();
      test_reset_mid();
`ifdef PLACAR_INC_EDGE_EN
      test_edge();
`else
      test_level();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/placar_bcd.md
Name: placar_bcd

Overview:
- Multi-digit BCD up/down score counter.
- Produces one 4-bit BCD digit per display position.
- Each digit feeds a per-digit 7-segment decoder instance.
- Sits directly upstream of the digit decoders; driven by game-logic pulses (point scored, penalty, reset score, preset).

Parameters:
- NDIG, 4, number of BCD digits (1..8); counter range 0 .. 10^NDIG-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- inc  in  1  increment request.
- dec  in  1  decrement request.
- clr  in  1  synchronous clear to zero.
- load  in  1  synchronous preset from valor_load.
- valor_load  in  4*NDIG  preset value, BCD; digit i at bits [4i+3:4i], digit 0 is least significant.
- digitos  out  4*NDIG  current count, BCD, same packing; every nibble 0..9.
- overflow  out  1  one-cycle pulse on wrap from all-9s to all-0s.
- underflow  out  1  one-cycle pulse on wrap from all-0s to all-9s.
- zero  out  1  high while digitos is all zeros.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at an edge): digitos=0, overflow=0, underflow=0, zero=1. Reset overrides every other input, including mid-operation.
- Latency: an action sampled at edge N is visible on digitos, overflow, underflow and zero right after edge N.
- Action priority, highest first: clr, load, (inc and dec both active: hold), inc, dec, hold.
- clr: digitos=0. No overflow or underflow pulse.
- load: each nibble of valor_load >9 is clamped to 9; other nibbles are copied unchanged. No pulse.
- inc: digit 0 counts up by 1. Digit i (i>0) counts up only when all lower digits equal 9. Any digit at 9 that counts up becomes 0 (carry chain, evaluated within one cycle).
- inc at all-9s: result is all-0s, and overflow=1 for exactly that cycle.
- dec: digit 0 counts down by 1. Digit i (i>0) counts down only when all lower digits equal 0. Any digit at 0 that counts down becomes 9 (borrow chain).
- dec at all-0s: result is all-9s, and underflow=1 for exactly that cycle.
- overflow and underflow are 0 in every cycle without a wrap. They are never both 1.
- zero is recomputed from the next value, so it is consistent with digitos in the same cycle.
- Invalid internal state cannot occur: only clamped loads and BCD arithmetic write the register.
- No state machine beyond the count register. The optional edge detector adds one flip-flop per request input.

Optional Feature:
- Macro: PLACAR_INC_EDGE_EN.
- Defined:
  - inc and dec are level inputs (e.g. synchronized pushbuttons).
  - Each registers its previous value (reset to 0).
  - The effective request is the rising edge only (cur=1, prev=0), so a held input counts once.
  - Priority and simultaneity rules apply to the detected edges.
- Undefined:
  - inc and dec are used directly.
  - Every cycle they are high counts once.

Test Plan:
- Reset and count: rst_n=0 for 2 cycles, then 3 single-cycle inc pulses -> digitos=16'h0003, zero=0. Before the first inc, zero=1.
- Carry across digits: load 16'h0999, then 1 inc -> 16'h1000. Load 16'h1000, then 1 dec -> 16'h0999. No pulses in either case.
- Wrap: load 16'h9999, inc -> 16'h0000, overflow=1 for one cycle, zero=1. Then dec -> 16'h9999, underflow=1 for one cycle.
- Priority and simultaneity:
  - inc=dec=1 at 16'h0042 -> stays 16'h0042.
  - clr=load=inc=1 -> 16'h0000.
  - load=1 with valor_load=16'hA5F3 -> 16'h9593.
- Reset mid-operation: inc held high; assert rst_n=0 for one edge -> 16'h0000, all pulses 0. Counting resumes on the next edge after rst_n=1 (macro undefined).
- With PLACAR_INC_EDGE_EN: inc held high for 10 cycles -> count increases by exactly 1. Release for 1 cycle and reassert -> count increases by 1 more.
